// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// fault codes and the size/alignment legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_TIMEOUT  = 2'd2,
      FAULT_ILLEGAL  = 2'd3
   } fault_t;

   // Unsigned byte/halfword variants only exist for loads.
   function automatic logic f3_legal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

   // Size is encoded in funct3[1:0] for both signed and unsigned variants.
   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return !off[0];
         2'b10:   return off == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and bus-side bundles of the load/store unit.
// Core side: the datapath is master, the LSU is slave.
interface lsu_core_if;
   logic        req_valid;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic [1:0]  fault;
   logic        done;

   modport master (output req_valid, we, funct3, addr, wdata,
                   input  rdata, stall, fault, done);
   modport slave  (input  req_valid, we, funct3, addr, wdata,
                   output rdata, stall, fault, done);
endinterface

// Bus side: the LSU is master, the memory is slave.
interface lsu_bus_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: byte enables and lane-replicated store data, plus
// extraction and sign/zero extension of load data. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] st_data_o,
   output logic [31:0] ld_data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select lanes by size and offset; funct3[2] chooses zero extension.
   always_comb begin
      be_o      = 4'b0000;
      st_data_o = '0;
      ld_data_o = '0;
      byte_v    = ld_word_i[{off_i, 3'b000} +: 8];
      half_v    = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
      case (funct3_i[1:0])
         2'b00: begin
            be_o      = 4'b0001 << off_i;
            st_data_o = {4{st_data_i[7:0]}};
            ld_data_o = funct3_i[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
         end
         2'b01: begin
            be_o      = off_i[1] ? 4'b1100 : 4'b0011;
            st_data_o = {2{st_data_i[15:0]}};
            ld_data_o = funct3_i[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
         end
         default: begin
            be_o      = 4'b1111;
            st_data_o = st_data_i;
            ld_data_o = ld_word_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: checks size and alignment, issues one request/grant bus
// transaction per access, stalls the core until completion, fault or timeout.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic      clk,
   input  logic      reset,
   lsu_core_if.slave core,
   lsu_bus_if.master bus
);

   localparam int unsigned   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT - 1);
   localparam bit            TO_EN = (TIMEOUT != 0);

   state_t        state_q;
   logic [31:0]   rdata_q;
   logic          req_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          done_q;
   fault_t        fault_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   logic          legal;
   logic          aligned;
   logic          expire;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata;
   logic [31:0]   al_rdata;

   // Address, data, size and direction are held by the core while stalled,
   // so one lane unit serves both request formatting and load capture.
   lsu_align u_align (
      .funct3_i  (core.funct3),
      .off_i     (core.addr[1:0]),
      .st_data_i (core.wdata),
      .ld_word_i (bus.mem_rdata),
      .be_o      (al_be),
      .st_data_o (al_wdata),
      .ld_data_o (al_rdata)
   );

   // Access checks and timeout bookkeeping.
   always_comb begin
      legal   = f3_legal(core.funct3, core.we);
      aligned = f3_aligned(core.funct3, core.addr[1:0]);
      cnt_d   = cnt_q + CW'(1);
      expire  = TO_EN && (cnt_q == TMAX);
   end

   // Access FSM with registered bus and completion outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         fault_q <= FAULT_NONE;
         cnt_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= FAULT_NONE;
         case (state_q)
            S_IDLE: begin
               if (core.req_valid) begin
                  if (!legal) begin
                     state_q <= S_ERR;
                     done_q  <= 1'b1;
                     fault_q <= FAULT_ILLEGAL;
                  end else if (!aligned) begin
                     state_q <= S_ERR;
                     done_q  <= 1'b1;
                     fault_q <= FAULT_MISALIGN;
                  end else begin
                     state_q <= S_REQ;
                     req_q   <= 1'b1;
                     we_q    <= core.we;
                     addr_q  <= {core.addr[31:2], 2'b00};
                     be_q    <= al_be;
                     wdata_q <= core.we ? al_wdata : '0;
                     cnt_q   <= '0;
                  end
               end
            end
            S_REQ: begin
               // A grant in the expiry cycle still completes the access.
               if (bus.mem_gnt) begin
                  req_q <= 1'b0;
                  cnt_q <= cnt_d;
                  if (we_q || bus.mem_rvalid) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     if (!we_q) rdata_q <= al_rdata;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end else if (expire) begin
                  req_q   <= 1'b0;
                  state_q <= S_ERR;
                  done_q  <= 1'b1;
                  fault_q <= FAULT_TIMEOUT;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  rdata_q <= al_rdata;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (expire) begin
                  state_q <= S_ERR;
                  done_q  <= 1'b1;
                  fault_q <= FAULT_TIMEOUT;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            // Completion lasts one cycle; req_valid here is the finishing access.
            S_DONE, S_ERR: state_q <= S_IDLE;
            default:       state_q <= S_IDLE;
         endcase
      end
   end

   assign core.stall = (state_q == S_IDLE && core.req_valid) ||
                       (state_q == S_REQ) || (state_q == S_WAIT);
   assign core.rdata = rdata_q;
   assign core.done  = done_q;
   assign core.fault = fault_q;

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed accesses push expected bus requests and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [1:0]  fault;
      logic [31:0] rdata;
   } resp_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   errors = 0;

   bus_exp_t  bq[$];
   resp_exp_t rq[$];
   bus_exp_t  mb;
   resp_exp_t mr;

   lsu_core_if core ();
   lsu_bus_if  bus ();

   lsu #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .core  (core.slave),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_bus(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      bus_exp_t e;
      e.we = w; e.addr = a; e.be = be; e.wdata = wd;
      bq.push_back(e);
   endtask

   task automatic exp_resp(input logic [1:0] f, input logic [31:0] rd);
      resp_exp_t e;
      e.fault = f; e.rdata = rd;
      rq.push_back(e);
   endtask

   // Monitor: accepted bus requests and completions against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_req && bus.mem_gnt) begin
            if (bq.size() == 0) begin
               tests++; errors++;
               $display("FAIL bus_unexpected: got addr %h expected none", bus.mem_addr);
            end else begin
               mb = bq.pop_front();
               chk("bus_we", bus.mem_we, mb.we);
               chk("bus_addr", bus.mem_addr, mb.addr);
               chk("bus_be", bus.mem_be, mb.be);
               chk("bus_wdata", bus.mem_wdata, mb.wdata);
            end
         end
         if (core.done) begin
            if (rq.size() == 0) begin
               tests++; errors++;
               $display("FAIL done_unexpected: got fault %0d expected none", core.fault);
            end else begin
               mr = rq.pop_front();
               chk("resp_fault", core.fault, mr.fault);
               chk("resp_rdata", core.rdata, mr.rdata);
            end
         end
      end
   end

   // One access from IDLE; gdly = REQ cycles before gnt (<0 never), rdly = cycles gnt->rvalid.
   task automatic access(input string nm, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gdly, input int rdly, input logic [31:0] rword,
                         output int ncyc, output int nstall, output int nreq);
      int gat;
      bit fin;
      gat = -1; fin = 0; ncyc = 0; nstall = 0; nreq = 0;
      core.req_valid = 1'b1; core.we = w; core.funct3 = f3; core.addr = a; core.wdata = wd;
      while (!fin && ncyc < 60) begin
         bus.mem_gnt = bus.mem_req && (nreq == gdly);
         if (bus.mem_gnt) gat = ncyc;
         bus.mem_rvalid = !w && (gat >= 0) && (ncyc - gat == rdly);
         bus.mem_rdata  = bus.mem_rvalid ? rword : 32'h0;
         if (bus.mem_req) nreq++;
         @(negedge clk);
         if (core.stall) nstall++;
         if (core.done) fin = 1;
         @(posedge clk); #1;
         ncyc++;
      end
      core.req_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      chk({nm, "_complete"}, 32'(fin), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int nc, ns, nr;
      core.req_valid = 0; core.we = 0; core.funct3 = 0; core.addr = 0; core.wdata = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("rst_rdata", core.rdata, 32'h0);
      chk("rst_req", bus.mem_req, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_be", bus.mem_be, 4'h0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
      chk("rst_done", core.done, 1'b0);
      chk("rst_fault", core.fault, 2'd0);
      chk("rst_stall", core.stall, 1'b0);
      @(posedge clk); #1;

      // SW, gnt in first REQ cycle
      exp_bus(1, 32'h100, 4'b1111, 32'hDEADBEEF); exp_resp(0, 32'h0);
      access("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, nc, ns, nr);
      chk("sw_cycles", nc, 3); chk("sw_stall", ns, 2);

      // LB / LBU, rvalid two cycles after gnt
      exp_bus(0, 32'h200, 4'b1000, 32'h0); exp_resp(0, 32'hFFFFFF80);
      access("lb", 0, 3'b000, 32'h203, 32'h0, 0, 2, 32'h80FF1234, nc, ns, nr);
      chk("lb_cycles", nc, 5);
      exp_bus(0, 32'h200, 4'b1000, 32'h0); exp_resp(0, 32'h00000080);
      access("lbu", 0, 3'b100, 32'h203, 32'h0, 0, 2, 32'h80FF1234, nc, ns, nr);

      // SH upper half, gnt one cycle late
      exp_bus(1, 32'h300, 4'b1100, 32'hABCDABCD); exp_resp(0, 32'h00000080);
      access("sh", 1, 3'b001, 32'h302, 32'h0000ABCD, 1, 0, 0, nc, ns, nr);
      chk("sh_cycles", nc, 4);

      // Misaligned accesses
      exp_resp(1, 32'h00000080);
      access("lh_mis", 0, 3'b001, 32'h301, 32'h0, 0, 0, 0, nc, ns, nr);
      chk("lh_mis_req", nr, 0); chk("lh_mis_cycles", nc, 2); chk("lh_mis_stall", ns, 1);
      exp_resp(1, 32'h00000080);
      access("sw_mis", 1, 3'b010, 32'h102, 32'h1, 0, 0, 0, nc, ns, nr);
      chk("sw_mis_req", nr, 0);

      // Illegal sizes, including priority over misalignment
      exp_resp(3, 32'h00000080);
      access("f3_011", 0, 3'b011, 32'h0, 32'h0, 0, 0, 0, nc, ns, nr);
      chk("f3_011_req", nr, 0);
      exp_resp(3, 32'h00000080);
      access("sbu", 1, 3'b100, 32'h0, 32'h0, 0, 0, 0, nc, ns, nr);
      chk("sbu_req", nr, 0);
      exp_resp(3, 32'h00000080);
      access("f3_111_mis", 0, 3'b111, 32'h3, 32'h0, 0, 0, 0, nc, ns, nr);

      // Timeout in REQ, then a stale rvalid
      exp_resp(2, 32'h00000080);
      access("to_req", 0, 3'b010, 32'h600, 32'h0, -1, 0, 0, nc, ns, nr);
      chk("to_req_reqcyc", nr, 4); chk("to_req_cycles", nc, 6);
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
      @(negedge clk); chk("stale_rdata", core.rdata, 32'h00000080);
      @(posedge clk); #1; bus.mem_rvalid = 0;
      @(negedge clk); chk("stale_rdata2", core.rdata, 32'h00000080);
      @(posedge clk); #1;

      // Timeout in WAIT
      exp_bus(0, 32'h604, 4'b1111, 32'h0); exp_resp(2, 32'h00000080);
      access("to_wait", 0, 3'b010, 32'h604, 32'h0, 0, 100, 0, nc, ns, nr);
      chk("to_wait_cycles", nc, 6);

      // Bus events in the expiry cycle win
      exp_bus(1, 32'h700, 4'b0010, 32'h5A5A5A5A); exp_resp(0, 32'h00000080);
      access("sb_late", 1, 3'b000, 32'h701, 32'h5A, 3, 0, 0, nc, ns, nr);
      chk("sb_late_reqcyc", nr, 4);
      exp_bus(0, 32'h400, 4'b0011, 32'h0); exp_resp(0, 32'hFFFF8765);
      access("lh_late", 0, 3'b001, 32'h400, 32'h0, 0, 3, 32'h12348765, nc, ns, nr);
      exp_bus(0, 32'h400, 4'b1100, 32'h0); exp_resp(0, 32'h00008001);
      access("lhu", 0, 3'b101, 32'h402, 32'h0, 0, 0, 32'h80017FFF, nc, ns, nr);

      // LW with gnt and rvalid together
      exp_bus(0, 32'h400, 4'b1111, 32'h0); exp_resp(0, 32'hCAFEF00D);
      access("lw_fast", 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'hCAFEF00D, nc, ns, nr);
      chk("lw_fast_cycles", nc, 3);

      // Reset while waiting for read data
      exp_bus(0, 32'h500, 4'b1111, 32'h0);
      core.req_valid = 1; core.we = 0; core.funct3 = 3'b010; core.addr = 32'h500;
      @(posedge clk); #1; bus.mem_gnt = 1;
      @(posedge clk); #1; bus.mem_gnt = 0;
      chk("wait_stall", core.stall, 1'b1);
      reset = 1'b1; #1; core.req_valid = 0; #1;
      chk("mid_rst_req", bus.mem_req, 1'b0);
      chk("mid_rst_rdata", core.rdata, 32'h0);
      chk("mid_rst_done", core.done, 1'b0);
      chk("mid_rst_stall", core.stall, 1'b0);
      reset = 1'b0;
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
      @(negedge clk); chk("post_rst_rdata", core.rdata, 32'h0);
      @(posedge clk); #1; bus.mem_rvalid = 0;

      exp_bus(0, 32'h104, 4'b1111, 32'h0); exp_resp(0, 32'h0BADF00D);
      access("lw_after", 0, 3'b010, 32'h104, 32'h0, 0, 1, 32'h0BADF00D, nc, ns, nr);

      repeat (2) @(posedge clk);
      chk("bus_q_drained", bq.size(), 0);
      chk("resp_q_drained", rq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult (address) and WriteData (store data), and returns the formatted value the datapath muxes in as ReadData.
- Bridges the core to a request/grant memory bus with variable latency.
- Stalls the core (freezes PC and register writeback) until each access completes, faults, or times out.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before a bus-timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  controller MemRead|MemWrite for the current instruction
- we  in  1  1=store, 0=load
- funct3  in  3  size/sign field Instr[14:12]
- addr  in  32  byte address from ALUResult
- wdata  in  32  store data from WriteData
- rdata  out  32  formatted load data to datapath ReadData
- stall  out  1  hold PC/RegWrite this cycle
- fault  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal size; valid only while done=1
- done  out  1  access completes this cycle
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus accepts the request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word

Behaviour:
- Reset values (asynchronous, immediate on reset): state=IDLE, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, done=0, fault=0, timeout counter=0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- stall is combinational: 1 when (state==IDLE && req_valid) or state==REQ or state==WAIT; 0 in DONE and ERR.
- The core holds addr, wdata, we and funct3 stable while stall=1.
- IDLE, req_valid=0: stay.
- IDLE, req_valid=1, legal and aligned: register the bus outputs, assert mem_req and go to REQ. The request reaches the bus one cycle after req_valid.
- Legal size: funct3 is 000, 001 or 010, or for loads also 100 or 101.
- Aligned: halfword needs addr[0]=0; word needs addr[1:0]=0.
- IDLE, illegal size: go to ERR with fault=3; no bus request.
- IDLE, misaligned: go to ERR with fault=1; no bus request.
- Illegal size is checked before alignment.
- REQ: hold mem_req and all bus outputs stable until mem_gnt.
- REQ, gnt, store: drop mem_req and go to DONE.
- REQ, gnt, load, rvalid the same cycle: capture the data and go to DONE.
- REQ, gnt, load, no rvalid: go to WAIT.
- WAIT: on mem_rvalid, capture the formatted data into rdata and go to DONE.
- Timeout counter:
  - cleared on entry to REQ; increments each cycle in REQ and WAIT.
  - when it reaches TIMEOUT (TIMEOUT≠0): drop mem_req and go to ERR with fault=2.
  - TIMEOUT=0: never expires.
- DONE: done=1 and fault=0 for exactly one cycle, then IDLE unconditionally. req_valid in DONE belongs to the completing instruction and is ignored.
- ERR: done=1 with fault held for exactly one cycle; rdata unchanged; then IDLE.
- rdata is updated only on load capture; it holds its value otherwise.
- Store formatting:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = wdata.
- Loads: mem_be uses the same lane masks as the matching store size; mem_wdata = 0.
- Load formatting:
  - byte is selected by addr[1:0]; halfword by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Boundaries and simultaneous events:
  - mem_rvalid outside REQ/WAIT is ignored. This covers stale responses after a timeout or reset.
  - mem_gnt outside REQ is ignored.
  - Timeout expiry and gnt/rvalid in the same cycle: the bus event wins and there is no fault.
  - Reset mid-access: immediate IDLE, mem_req=0; any later rvalid is dropped.
  - Back-to-back accesses: minimum 3 cycles per access (IDLE→REQ→DONE) with gnt and rvalid at the first opportunity.

Decomposition:
- lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum
  - fault codes FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT, FAULT_ILLEGAL
- Sub-module lsu_align: combinational lane logic, producing be and wdata for stores and extracted, extended rdata for loads. It is instantiated once and used by the FSM top.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in the first REQ cycle → mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF; stall high 2 cycles, done on the 3rd, fault=0.
- LB addr=0x203, mem_rdata=0x80FF_1234, rvalid 2 cycles after gnt → be=1000, rdata=0xFFFFFF80. The same access as LBU → rdata=0x00000080.
- SH addr=0x302, wdata=0x0000ABCD → be=1100, mem_wdata=0xABCDABCD. LH addr=0x301 → no mem_req; ERR with fault=1, done=1 for one cycle, rdata unchanged.
- funct3=011 load → fault=3, no mem_req. Load with TIMEOUT=4 and gnt never asserted → mem_req high 4 cycles, then fault=2; a late rvalid with 0x12345678 leaves rdata unchanged.
- Load with gnt and rvalid in the same cycle, mem_rdata=0xCAFEF00D, LW addr=0x400 → rdata=0xCAFEF00D in DONE; total 3 cycles.
- Reset asserted in WAIT → mem_req=0, state IDLE, rdata=0 immediately; a following rvalid is ignored, and the next LW completes normally.
